// File: rtl/exe_iter_divider.sv
// exe_iter_divider
// Multi-cycle radix-2 restoring divider for the EXE stage. It takes one signed
// or unsigned divide per handshake, iterates once per clock for WIDTH cycles,
// and returns the quotient, the remainder and a pass-through tag.
//
// Ports:
//   clk, reset       clock and asynchronous active-high reset
//   flush            synchronous cancel of any in-flight or held operation
//   in_valid/ready   request handshake (in_ready depends on out_ready)
//   in_signed        1 = signed divide, 0 = unsigned divide
//   in_dividend      dividend, sampled on accept only
//   in_divisor       divisor, sampled on accept only
//   in_tag           opaque tag returned with the result
//   out_valid/ready  result handshake; the result is held while out_ready is low
//   out_quotient     quotient, truncated toward zero
//   out_remainder    remainder, carries the sign of the dividend
//   out_tag          tag of the operation that produced this result
//   out_div_zero     divisor was zero (quotient all ones, remainder = dividend)
//   busy             divider is not idle
module exe_iter_divider #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_div_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   div_mag_q, div_mag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [WIDTH-1:0]   out_quotient_q, out_quotient_d;
  logic [WIDTH-1:0]   out_remainder_q, out_remainder_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic               out_div_zero_q, out_div_zero_d;

  logic               accept;
  logic               dividend_neg, divisor_neg;
  logic [WIDTH-1:0]   dividend_mag, divisor_mag;
  logic [WIDTH:0]     shifted;
  logic               trial_ge;
  logic [WIDTH-1:0]   iter_rem, iter_quo;

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready && !flush;

  // Two's-complement absolute value; the most negative value maps onto
  // 2^(WIDTH-1) when read as unsigned, which is exactly what the iteration needs.
  assign dividend_neg = in_signed && in_dividend[WIDTH-1];
  assign divisor_neg  = in_signed && in_divisor[WIDTH-1];
  assign dividend_mag = dividend_neg ? (~in_dividend + 1'b1) : in_dividend;
  assign divisor_mag  = divisor_neg  ? (~in_divisor  + 1'b1) : in_divisor;

  // One restoring step. The partial remainder is always below the divisor, so
  // it fits in WIDTH bits; only the shifted value needs the extra bit. When the
  // trial subtraction succeeds its result is again below the divisor, so the
  // WIDTH-bit difference is exact.
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign trial_ge = (shifted >= {1'b0, div_mag_q});
  assign iter_rem = trial_ge ? (shifted[WIDTH-1:0] - div_mag_q) : shifted[WIDTH-1:0];
  assign iter_quo = {quo_q[WIDTH-2:0], trial_ge};

  // Next-state logic. Flush wins over everything; an accept overrides the
  // DONE -> IDLE return so back-to-back operations lose no cycle.
  always_comb begin
    state_d         = state_q;
    rem_d           = rem_q;
    quo_d           = quo_q;
    div_mag_d       = div_mag_q;
    cnt_d           = cnt_q;
    sign_a_d        = sign_a_q;
    sign_b_d        = sign_b_q;
    tag_d           = tag_q;
    out_quotient_d  = out_quotient_q;
    out_remainder_d = out_remainder_q;
    out_tag_d       = out_tag_q;
    out_div_zero_d  = out_div_zero_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        CALC: begin
          rem_d = iter_rem;
          quo_d = iter_quo;
          if (cnt_q == '0) begin
            // Sign fix-up is registered together with the final step.
            state_d         = DONE;
            out_quotient_d  = (sign_a_q ^ sign_b_q) ? (~iter_quo + 1'b1) : iter_quo;
            out_remainder_d = sign_a_q ? (~iter_rem + 1'b1) : iter_rem;
            out_tag_d       = tag_q;
            out_div_zero_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: ;
      endcase

      if (accept) begin
        sign_a_d = dividend_neg;
        sign_b_d = divisor_neg;
        tag_d    = in_tag;
        if (in_divisor == '0) begin
          state_d         = DONE;
          out_quotient_d  = '1;
          out_remainder_d = in_dividend;
          out_tag_d       = in_tag;
          out_div_zero_d  = 1'b1;
        end else begin
          state_d   = CALC;
          rem_d     = '0;
          quo_d     = dividend_mag;
          div_mag_d = divisor_mag;
          cnt_d     = CNT_W'(WIDTH - 1);
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      rem_q           <= '0;
      quo_q           <= '0;
      div_mag_q       <= '0;
      cnt_q           <= '0;
      sign_a_q        <= 1'b0;
      sign_b_q        <= 1'b0;
      tag_q           <= '0;
      out_quotient_q  <= '0;
      out_remainder_q <= '0;
      out_tag_q       <= '0;
      out_div_zero_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      rem_q           <= rem_d;
      quo_q           <= quo_d;
      div_mag_q       <= div_mag_d;
      cnt_q           <= cnt_d;
      sign_a_q        <= sign_a_d;
      sign_b_q        <= sign_b_d;
      tag_q           <= tag_d;
      out_quotient_q  <= out_quotient_d;
      out_remainder_q <= out_remainder_d;
      out_tag_q       <= out_tag_d;
      out_div_zero_q  <= out_div_zero_d;
    end
  end

  assign out_valid     = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign out_quotient  = out_quotient_q;
  assign out_remainder = out_remainder_q;
  assign out_tag       = out_tag_q;
  assign out_div_zero  = out_div_zero_q;

endmodule
